// File: rtl/id_rf_pkg.sv
// id_rf_pkg: shared types and default widths for the decode/register-read stage
package id_rf_pkg;
  localparam int DATA_W_DEF  = 16;
  localparam int NREG_DEF    = 8;
  localparam int CONST_W_DEF = 12;
  typedef enum logic [2:0] {
    EXT_ZEXT  = 3'd0,
    EXT_SEXT  = 3'd1,
    EXT_ZEXT8 = 3'd2,
    EXT_SEXT8 = 3'd3,
    EXT_HI8   = 3'd4
  } ext_mode_t;
  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MD  = 1'b1
  } wb_src_t;
endpackage

// File: rtl/reg_bank_n.sv
// reg_bank_n: NREG x DATA_W register bank, two async read ports, one sync write port
// ports: clk, rst_n (async, active-low), we_i/waddr_i/wdata_i write port,
//        raddr_a_i/raddr_b_i -> rdata_a_o/rdata_b_o combinational reads
module reg_bank_n #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int ADDR_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);
  logic [DATA_W-1:0] regs_q [NREG];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) regs_q <= '{default: '0};
    else if (we_i) regs_q[waddr_i] <= wdata_i;
  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];
endmodule

// File: rtl/id_rf_pipe.sv
// id_rf_pipe: decode/register-read stage with register bank, wb mux, const extender and ID/EX slot
// ports: clock, reset_n (async, active-low); in_valid/in_ready/in_sel_a/in_sel_b/in_ext_mode/in_const
//        request side; wb_en/wb_addr/wb_src/wb_alu/wb_md write-back; flush; out_valid/out_ready and
//        out_a/out_b/out_const/out_sel_a/out_sel_b slot outputs.
// option: define ID_RF_BYPASS_EN for write-through on capture and held-operand refresh while stalled.
module id_rf_pipe
  import id_rf_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int CONST_W = CONST_W_DEF,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_sel_a,
  input  logic [ADDR_W-1:0]  in_sel_b,
  input  logic [2:0]         in_ext_mode,
  input  logic [CONST_W-1:0] in_const,
  input  logic               wb_en,
  input  logic [ADDR_W-1:0]  wb_addr,
  input  logic               wb_src,
  input  logic [DATA_W-1:0]  wb_alu,
  input  logic [DATA_W-1:0]  wb_md,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_a,
  output logic [DATA_W-1:0]  out_b,
  output logic [DATA_W-1:0]  out_const,
  output logic [ADDR_W-1:0]  out_sel_a,
  output logic [ADDR_W-1:0]  out_sel_b
);
  logic              valid_q, valid_d, cap;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [ADDR_W-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [DATA_W-1:0] rd_a, rd_b, wb_data, op_a, op_b, hold_a, hold_b, const_ext;
  reg_bank_n #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) u_bank (
    .clk(clock), .rst_n(reset_n),
    .we_i(wb_en), .waddr_i(wb_addr), .wdata_i(wb_data),
    .raddr_a_i(in_sel_a), .raddr_b_i(in_sel_b),
    .rdata_a_o(rd_a), .rdata_b_o(rd_b)
  );
  assign wb_data  = (wb_src == WB_MD) ? wb_md : wb_alu;
  assign in_ready = !valid_q || out_ready;
  assign cap      = in_valid && in_ready && !flush;
  assign const_ext =
    (in_ext_mode == EXT_ZEXT)  ? DATA_W'(in_const) :
    (in_ext_mode == EXT_SEXT)  ? DATA_W'($signed(in_const)) :
    (in_ext_mode == EXT_ZEXT8) ? DATA_W'(in_const[7:0]) :
    (in_ext_mode == EXT_SEXT8) ? DATA_W'($signed(in_const[7:0])) :
    (in_ext_mode == EXT_HI8)   ? {in_const[7:0], {(DATA_W-8){1'b0}}} : '0;
`ifdef ID_RF_BYPASS_EN
  logic stall;
  assign stall  = valid_q && !out_ready;
  assign op_a   = (wb_en && wb_addr == in_sel_a) ? wb_data : rd_a;
  assign op_b   = (wb_en && wb_addr == in_sel_b) ? wb_data : rd_b;
  assign hold_a = (stall && wb_en && wb_addr == sa_q) ? wb_data : a_q;
  assign hold_b = (stall && wb_en && wb_addr == sb_q) ? wb_data : b_q;
`else
  assign op_a   = rd_a;
  assign op_b   = rd_b;
  assign hold_a = a_q;
  assign hold_b = b_q;
`endif
  always_comb begin
    valid_d = flush ? 1'b0 : cap ? 1'b1 : valid_q && !out_ready;
    a_d     = cap ? op_a : hold_a;
    b_d     = cap ? op_b : hold_b;
    c_d     = cap ? const_ext : c_q;
    sa_d    = cap ? in_sel_a : sa_q;
    sb_d    = cap ? in_sel_b : sb_q;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  assign out_valid = valid_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_const = c_q;
  assign out_sel_a = sa_q;
  assign out_sel_b = sb_q;
endmodule
